// File: rtl/wishbone_pwm_bank_pkg.sv
// Shared register map, CTRL/CFG/STATUS bit positions and byte-lane helper
// for the Wishbone PWM bank.
package wishbone_pwm_bank_pkg;

  localparam int REG_CTRL      = 'h00;
  localparam int REG_PERIOD    = 'h01;
  localparam int REG_STATUS    = 'h02;
  localparam int REG_CH_BASE   = 'h10;
  localparam int REG_CH_STRIDE = 4;

  localparam int CTRL_EN            = 0;
  localparam int CTRL_UPDATE        = 1;
  localparam int CTRL_IRQ_EN        = 2;
  localparam int STATUS_UPD_PENDING = 0;
  localparam int CFG_CH_EN          = 0;
  localparam int CFG_INVERT         = 1;

  typedef enum logic [1:0] {
    CH_DUTY  = 2'd0,
    CH_PHASE = 2'd1,
    CH_CFG   = 2'd2,
    CH_RSVD  = 2'd3
  } ch_reg_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] stb);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{stb[l]}};
    return m;
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: phase-offset counter that tracks (cnt - PHASE) mod PERIOD
// without a divider, plus the duty compare and the registered output.
module pwm_bank_channel #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [CNT_WIDTH-1:0] period_act,
  input  logic [CNT_WIDTH-1:0] period_nxt,
  input  logic [CNT_WIDTH-1:0] phase_nxt,
  input  logic [CNT_WIDTH-1:0] duty_act,
  input  logic                 out_en,
  input  logic                 invert,
  output logic                 pwm
);

  logic [CNT_WIDTH-1:0] pc;
  logic [CNT_WIDTH-1:0] start;
  logic                 active;

  // Value of (0 - phase) mod period; out-of-range phase behaves as zero.
  always_comb begin
    start = '0;
    if (phase_nxt != '0 && phase_nxt < period_nxt) start = period_nxt - phase_nxt;
  end

  assign active = (period_act != '0) && (pc < duty_act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= '0;
      pwm <= 1'b0;
    end else begin
      pwm <= (active & out_en) ^ invert;
      if (restart)                         pc <= start;
      else if (pc == period_act - 1'b1)    pc <= '0;
      else                                 pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/wishbone_pwm_bank.sv
// Wishbone-controlled bank of phase-shifted PWM channels sharing one period
// counter, with double-buffered PERIOD/DUTY/PHASE and a wrap interrupt.
module wishbone_pwm_bank
  import wishbone_pwm_bank_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int ADDR_WIDTH     = 17,
  parameter int MUX_ADDR_WIDHT = 9,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                 WB_CLK,
  input  logic                                 WB_RST,
  input  logic                                 WBS_CYC,
  input  logic                                 WBS_STB,
  input  logic                                 WBS_WE,
  input  logic                                 WBS_RD,
  input  logic [ADDR_WIDTH-MUX_ADDR_WIDHT-1:0] WBS_ADR,
  input  logic [DATA_WIDTH-1:0]                WBS_WR_DAT,
  input  logic [3:0]                           WBS_BYTE_STB,
  output logic [DATA_WIDTH-1:0]                WBS_RD_DAT,
  output logic                                 WBS_ACK,
  output logic [NUM_CH-1:0]                    PWM_OUT,
  output logic                                 PERIOD_IRQ
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  logic              en, irq_en, upd_pending;
  cnt_t              period_sh, period_act, cnt;
  cnt_t              duty_sh [NUM_CH];
  cnt_t              phase_sh [NUM_CH];
  cnt_t              duty_act [NUM_CH];
  cnt_t              phase_act [NUM_CH];
  logic [NUM_CH-1:0] ch_en, invert;

  // Handshake: a request is CYC&STB sampled while ACK is low; the access is
  // performed on that edge and ACK is raised for exactly the following cycle,
  // so ACK can never be asserted in two consecutive cycles.
  logic req, wr, rd;
  assign req = WBS_CYC & WBS_STB & ~WBS_ACK;
  assign wr  = req & WBS_WE;
  assign rd  = req & ~WBS_WE & WBS_RD;

  logic [31:0]           idx;
  logic                  hit_ctrl, hit_period, hit_status;
  logic [NUM_CH-1:0]     hit_duty, hit_phase, hit_cfg;
  logic [DATA_WIDTH-1:0] wmask, rd_mux;

  assign idx   = 32'(WBS_ADR);
  assign wmask = DATA_WIDTH'(lane_mask(WBS_BYTE_STB));

  always_comb begin
    hit_ctrl   = (idx == 32'(REG_CTRL));
    hit_period = (idx == 32'(REG_PERIOD));
    hit_status = (idx == 32'(REG_STATUS));
    hit_duty   = '0;
    hit_phase  = '0;
    hit_cfg    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit_duty[c]  = (idx == 32'(REG_CH_BASE + REG_CH_STRIDE*c + int'(CH_DUTY)));
      hit_phase[c] = (idx == 32'(REG_CH_BASE + REG_CH_STRIDE*c + int'(CH_PHASE)));
      hit_cfg[c]   = (idx == 32'(REG_CH_BASE + REG_CH_STRIDE*c + int'(CH_CFG)));
    end
  end

  always_comb begin
    rd_mux = '0;
    if (hit_ctrl) begin
      rd_mux[CTRL_EN]     = en;
      rd_mux[CTRL_IRQ_EN] = irq_en;
    end
    if (hit_period) rd_mux = DATA_WIDTH'(period_sh);
    if (hit_status) rd_mux[STATUS_UPD_PENDING] = upd_pending;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit_duty[c])  rd_mux = DATA_WIDTH'(duty_sh[c]);
      if (hit_phase[c]) rd_mux = DATA_WIDTH'(phase_sh[c]);
      if (hit_cfg[c]) begin
        rd_mux[CFG_CH_EN]  = ch_en[c];
        rd_mux[CFG_INVERT] = invert[c];
      end
    end
  end

  function automatic cnt_t merge_cnt(input cnt_t old, input logic [DATA_WIDTH-1:0] d,
                                     input logic [DATA_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] w;
    w = (DATA_WIDTH'(old) & ~m) | (d & m);
    return cnt_t'(w);
  endfunction

  // A zero period never wraps, so pending updates load immediately there,
  // exactly as they do while the bank is disabled.
  logic period_zero, wrap, load, restart;
  cnt_t period_nxt;
  assign period_zero = (period_act == '0);
  assign wrap        = en & ~period_zero & (cnt == period_act - 1'b1);
  assign load        = upd_pending & (wrap | ~en | period_zero);
  assign restart     = ~en | period_zero | wrap;
  assign period_nxt  = load ? period_sh : period_act;

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      WBS_ACK     <= 1'b0;
      WBS_RD_DAT  <= '0;
      PERIOD_IRQ  <= 1'b0;
      en          <= 1'b0;
      irq_en      <= 1'b0;
      upd_pending <= 1'b0;
      period_sh   <= '0;
      period_act  <= '0;
      cnt         <= '0;
      ch_en       <= '0;
      invert      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_sh[c]   <= '0;
        phase_sh[c]  <= '0;
        duty_act[c]  <= '0;
        phase_act[c] <= '0;
      end
    end else begin
      WBS_ACK    <= req;
      WBS_RD_DAT <= rd ? rd_mux : '0;
      PERIOD_IRQ <= wrap & irq_en;
      cnt        <= restart ? '0 : cnt + 1'b1;
      if (load) begin
        period_act  <= period_sh;
        upd_pending <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          duty_act[c]  <= duty_sh[c];
          phase_act[c] <= phase_sh[c];
        end
      end
      // A fresh UPDATE on the load cycle stays pending for the next wrap.
      if (wr && hit_ctrl && WBS_BYTE_STB[0]) begin
        en     <= WBS_WR_DAT[CTRL_EN];
        irq_en <= WBS_WR_DAT[CTRL_IRQ_EN];
        if (WBS_WR_DAT[CTRL_UPDATE]) upd_pending <= 1'b1;
      end
      if (wr && hit_period) period_sh <= merge_cnt(period_sh, WBS_WR_DAT, wmask);
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr && hit_duty[c])  duty_sh[c]  <= merge_cnt(duty_sh[c], WBS_WR_DAT, wmask);
        if (wr && hit_phase[c]) phase_sh[c] <= merge_cnt(phase_sh[c], WBS_WR_DAT, wmask);
        if (wr && hit_cfg[c] && WBS_BYTE_STB[0]) begin
          ch_en[c]  <= WBS_WR_DAT[CFG_CH_EN];
          invert[c] <= WBS_WR_DAT[CFG_INVERT];
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_bank_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk        (WB_CLK),
      .rst        (WB_RST),
      .restart    (restart),
      .period_act (period_act),
      .period_nxt (period_nxt),
      .phase_nxt  (load ? phase_sh[c] : phase_act[c]),
      .duty_act   (duty_act[c]),
      .out_en     (en & ch_en[c]),
      .invert     (invert[c]),
      .pwm        (PWM_OUT[c])
    );
  end

endmodule

// File: tb/tb_wishbone_pwm_bank.sv
// Bench for wishbone_pwm_bank: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wishbone_pwm_bank;

  logic        WB_CLK, WB_RST;
  logic        WBS_CYC, WBS_STB, WBS_WE, WBS_RD;
  logic [7:0]  WBS_ADR;
  logic [31:0] WBS_WR_DAT, WBS_RD_DAT;
  logic [3:0]  WBS_BYTE_STB;
  logic        WBS_ACK, PERIOD_IRQ;
  logic [3:0]  PWM_OUT;

  wishbone_pwm_bank dut (
    .WB_CLK(WB_CLK), .WB_RST(WB_RST), .WBS_CYC(WBS_CYC), .WBS_STB(WBS_STB),
    .WBS_WE(WBS_WE), .WBS_RD(WBS_RD), .WBS_ADR(WBS_ADR), .WBS_WR_DAT(WBS_WR_DAT),
    .WBS_BYTE_STB(WBS_BYTE_STB), .WBS_RD_DAT(WBS_RD_DAT), .WBS_ACK(WBS_ACK),
    .PWM_OUT(PWM_OUT), .PERIOD_IRQ(PERIOD_IRQ)
  );

  // ---------------- clock / reset ----------------
  initial begin
    WB_CLK = 1'b0;
    forever #5 WB_CLK = ~WB_CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_chk = 0, n_pass = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_per_sh, m_per_act;
  logic [15:0] m_duty_sh[4], m_phase_sh[4], m_duty_act[4], m_phase_act[4];
  logic        m_en, m_irq_en, m_upd;
  logic [3:0]  m_chen, m_inv;
  int          m_cnt;
  logic [3:0]  e_pwm;
  logic        e_irq, e_ack;
  logic [31:0] e_rd;

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] r;
    int c, s;
    r = 32'h0;
    if (idx == 0) r = {29'b0, m_irq_en, 1'b0, m_en};
    else if (idx == 1) r = {16'b0, m_per_sh};
    else if (idx == 2) r = {31'b0, m_upd};
    else if (idx >= 16 && idx < 32) begin
      c = (idx - 16) / 4;
      s = (idx - 16) % 4;
      if (s == 0) r = {16'b0, m_duty_sh[c]};
      else if (s == 1) r = {16'b0, m_phase_sh[c]};
      else if (s == 2) r = {30'b0, m_inv[c], m_chen[c]};
    end
    return r;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = {16'b0, old};
    for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = d[8*l +: 8];
    return r[15:0];
  endfunction

  task automatic model_reset();
    m_per_sh = 0; m_per_act = 0; m_en = 0; m_irq_en = 0; m_upd = 0;
    m_chen = 0; m_inv = 0; m_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      m_duty_sh[c] = 0; m_phase_sh[c] = 0; m_duty_act[c] = 0; m_phase_act[c] = 0;
    end
    e_pwm = 0; e_irq = 0; e_ack = 0; e_rd = 0;
  endtask

  task automatic model_step();
    int p, ph, idx, c, s, off;
    logic wrap, load, req, wr, set_upd, act;
    logic [3:0] nxt_pwm;
    p = int'(m_per_act);
    for (int k = 0; k < 4; k++) begin
      act = 1'b0;
      if (p != 0) begin
        ph  = (int'(m_phase_act[k]) >= p) ? 0 : int'(m_phase_act[k]);
        off = (((m_cnt - ph) % p) + p) % p;
        act = (off < int'(m_duty_act[k]));
      end
      nxt_pwm[k] = (act & m_chen[k] & m_en) ^ m_inv[k];
    end
    wrap  = m_en && p != 0 && m_cnt == p - 1;
    load  = m_upd && (wrap || !m_en || p == 0);
    req   = WBS_CYC && WBS_STB && !e_ack;
    wr    = req && WBS_WE;
    idx   = int'(WBS_ADR);
    e_rd  = (req && !WBS_WE && WBS_RD) ? m_read(idx) : 32'h0;
    e_ack = req;
    e_irq = wrap && m_irq_en;
    e_pwm = nxt_pwm;
    m_cnt = (!m_en || p == 0 || wrap) ? 0 : m_cnt + 1;
    if (load) begin
      m_per_act = m_per_sh;
      for (int k = 0; k < 4; k++) begin
        m_duty_act[k] = m_duty_sh[k]; m_phase_act[k] = m_phase_sh[k];
      end
    end
    set_upd = 1'b0;
    if (wr) begin
      if (idx == 0 && WBS_BYTE_STB[0]) begin
        m_en = WBS_WR_DAT[0]; m_irq_en = WBS_WR_DAT[2]; set_upd = WBS_WR_DAT[1];
      end else if (idx == 1) m_per_sh = merge(m_per_sh, WBS_WR_DAT, WBS_BYTE_STB);
      else if (idx >= 16 && idx < 32) begin
        c = (idx - 16) / 4;
        s = (idx - 16) % 4;
        if (s == 0) m_duty_sh[c] = merge(m_duty_sh[c], WBS_WR_DAT, WBS_BYTE_STB);
        else if (s == 1) m_phase_sh[c] = merge(m_phase_sh[c], WBS_WR_DAT, WBS_BYTE_STB);
        else if (s == 2 && WBS_BYTE_STB[0]) begin
          m_chen[c] = WBS_WR_DAT[0]; m_inv[c] = WBS_WR_DAT[1];
        end
      end
    end
    if (load) m_upd = 1'b0;
    if (set_upd) m_upd = 1'b1;
  endtask

  always @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) model_reset();
    else model_step();
  end

  // Compare process: all outputs are registered, so check on the falling edge.
  always @(negedge WB_CLK) begin
    if (cmp_on) begin
      chk("pwm_out", 32'(PWM_OUT), 32'(e_pwm));
      chk("period_irq", 32'(PERIOD_IRQ), 32'(e_irq));
      chk("wbs_ack", 32'(WBS_ACK), 32'(e_ack));
      chk("wbs_rd_dat", WBS_RD_DAT, e_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_xfer(input logic we, input int idx, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] q);
    bit got;
    got = 0;
    q = 32'h0;
    @(negedge WB_CLK);
    WBS_CYC = 1; WBS_STB = 1; WBS_WE = we; WBS_RD = !we;
    WBS_ADR = 8'(idx); WBS_WR_DAT = d; WBS_BYTE_STB = be;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge WB_CLK);
      if (WBS_ACK) begin got = 1; q = WBS_RD_DAT; end
    end
    WBS_CYC = 0; WBS_STB = 0; WBS_WE = 0; WBS_RD = 0;
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    logic [31:0] q;
    bus_xfer(1'b1, idx, d, 4'hF, q);
  endtask

  task automatic rd_chk(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] q;
    bus_xfer(1'b0, idx, 32'h0, 4'hF, q);
    chk(name, q, exp);
  endtask

  logic [3:0] smp[64];
  logic       sirq[64];

  task automatic sample(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge WB_CLK);
      smp[t] = PWM_OUT; sirq[t] = PERIOD_IRQ;
    end
  endtask

  function automatic int count_ch(input int ch, input int n);
    int k;
    k = 0;
    for (int t = 0; t < n; t++) if (smp[t][ch]) k++;
    return k;
  endfunction

  task automatic wait_irq(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge WB_CLK);
      if (PERIOD_IRQ) got = 1;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic duty_case(input string name, input logic [31:0] duty, input int exp_cnt);
    wr('h10, duty);
    wr('h00, 32'h7);
    repeat (25) @(negedge WB_CLK);
    sample(20);
    chk(name, count_ch(0, 20), exp_cnt);
  endtask

  function automatic int pick_idx();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 1) return 0;
    if (r == 2) return 1;
    if (r == 3) return 2;
    if (r <= 8) return 16 + $urandom_range(0, 15);
    return $urandom_range(0, 255);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, diff;
    logic [31:0] q, d;
    WB_RST = 1; WBS_CYC = 0; WBS_STB = 0; WBS_WE = 0; WBS_RD = 0;
    WBS_ADR = 0; WBS_WR_DAT = 0; WBS_BYTE_STB = 0;
    @(posedge WB_CLK);
    cmp_on = 1;
    repeat (2) @(negedge WB_CLK);
    WB_RST = 0;

    chk("reset_pwm", 32'(PWM_OUT), 32'h0);
    rd_chk("reset_ctrl", 'h00, 32'h0);
    rd_chk("reset_status", 'h02, 32'h0);

    // Byte lanes and unmapped reads
    wr('h01, 32'h1234);
    bus_xfer(1'b1, 'h01, 32'hFFFF, 4'b0001, q);
    rd_chk("byte_lane_period", 'h01, 32'h12FF);
    rd_chk("unmapped_7f", 'h7F, 32'h0);

    // Basic waveform, phase offset and IRQ cadence
    wr('h01, 10);
    wr('h10, 3); wr('h11, 0); wr('h12, 1);
    wr('h14, 3); wr('h15, 5); wr('h16, 1);
    wr('h00, 32'h2);
    wr('h00, 32'h5);
    repeat (5) @(negedge WB_CLK);
    sample(30);
    chk("ch0_duty3_count", count_ch(0, 20), 6);
    t0 = 0;
    for (int t = 0; t < 20; t++) if (sirq[t]) t0++;
    chk("irq_count", t0, 2);
    t0 = -1; t1 = -1;
    for (int t = 1; t < 30; t++) if (t0 < 0 && smp[t][0] && !smp[t-1][0]) t0 = t;
    for (int t = 1; t < 30; t++)
      if (t0 >= 0 && t1 < 0 && t > t0 && smp[t][1] && !smp[t-1][1]) t1 = t;
    diff = t1 - t0;
    chk("ch1_phase5_offset", diff, 5);

    // Phase beyond period behaves as zero
    wr('h15, 12);
    wr('h00, 32'h7);
    repeat (25) @(negedge WB_CLK);
    sample(20);
    diff = 0;
    for (int t = 0; t < 20; t++) if (smp[t][1] != smp[t][0]) diff++;
    chk("phase12_aligned", diff, 0);
    chk("ch1_phase12_count", count_ch(1, 20), 6);

    // Shadow write without UPDATE, then UPDATE and STATUS
    wr('h10, 7);
    repeat (12) @(negedge WB_CLK);
    sample(20);
    chk("duty_shadow_only", count_ch(0, 20), 6);
    wait_irq("irq_before_update");
    wr('h00, 32'h7);
    rd_chk("status_pending", 'h02, 32'h1);
    wait_irq("irq_at_load");
    rd_chk("status_cleared", 'h02, 32'h0);
    sample(20);
    chk("duty7_count", count_ch(0, 20), 14);

    // Duty boundaries, inversion and zero period
    duty_case("duty0_count", 0, 0);
    duty_case("duty10_count", 10, 20);
    duty_case("duty15_count", 15, 20);
    wr('h12, 3);
    duty_case("invert_duty3_count", 3, 14);
    wr('h01, 0);
    wr('h00, 32'h7);
    repeat (5) @(negedge WB_CLK);
    sample(20);
    chk("period0_inverted_ch0", count_ch(0, 20), 20);
    chk("period0_plain_ch1", count_ch(1, 20), 0);

    // Randomized register traffic
    wr('h01, 7);
    wr('h00, 32'h7);
    for (int it = 0; it < 300; it++) begin
      int idx;
      idx = pick_idx();
      if ($urandom_range(0, 2) == 0) begin
        bus_xfer(1'b0, idx, 32'h0, 4'hF, q);
      end else begin
        if (idx == 0) d = 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 3) != 0);
        else if ($urandom_range(0, 15) == 0) d = $urandom;
        else d = 32'($urandom_range(0, 14));
        bus_xfer(1'b1, idx, d, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, q);
      end
      repeat ($urandom_range(0, 6)) @(negedge WB_CLK);
    end

    // Asynchronous reset with an ACK in flight
    wr('h00, 32'h0);
    wr('h12, 32'h2);
    repeat (2) @(negedge WB_CLK);
    chk("pre_reset_pwm0", 32'(PWM_OUT[0]), 32'h1);
    @(negedge WB_CLK);
    WBS_CYC = 1; WBS_STB = 1; WBS_WE = 1; WBS_RD = 0;
    WBS_ADR = 8'h01; WBS_WR_DAT = 32'h55; WBS_BYTE_STB = 4'hF;
    @(posedge WB_CLK);
    #2;
    chk("ack_before_reset", 32'(WBS_ACK), 32'h1);
    WB_RST = 1;
    #1;
    chk("async_ack", 32'(WBS_ACK), 32'h0);
    chk("async_pwm", 32'(PWM_OUT), 32'h0);
    chk("async_rd_dat", WBS_RD_DAT, 32'h0);
    chk("async_irq", 32'(PERIOD_IRQ), 32'h0);
    WBS_CYC = 0; WBS_STB = 0; WBS_WE = 0;
    repeat (3) @(negedge WB_CLK);
    WB_RST = 0;
    rd_chk("post_reset_ctrl", 'h00, 32'h0);
    rd_chk("post_reset_period", 'h01, 32'h0);
    rd_chk("post_reset_status", 'h02, 32'h0);
    rd_chk("post_reset_duty0", 'h10, 32'h0);
    rd_chk("post_reset_phase1", 'h15, 32'h0);
    rd_chk("post_reset_cfg0", 'h12, 32'h0);
    repeat (3) @(negedge WB_CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wishbone_pwm_bank.md
WISHBONE_PWM_BANK -- requirements
Module: wishbone_pwm_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of PWM channels (1..16).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the counter, period, duty and phase fields (2..32).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 17, giving the Wishbone address width.
REQ-004 The block SHALL have parameter MUX_ADDR_WIDHT, default 9, giving the number of interconnect-decoded upper address bits.
REQ-005 The block SHALL have parameter DATA_WIDTH, default 32, giving the Wishbone data width.
REQ-006 The block SHALL have port WB_CLK, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-007 The block SHALL have port WB_RST, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have ports WBS_CYC, WBS_STB, WBS_WE and WBS_RD, inputs, 1 bit each: cycle, strobe, write enable and read enable.
REQ-009 The block SHALL have port WBS_ADR, input, ADDR_WIDTH-MUX_ADDR_WIDHT bits: word register index.
REQ-010 The block SHALL have ports WBS_WR_DAT (input, DATA_WIDTH), WBS_BYTE_STB (input, 4) and WBS_RD_DAT (output, DATA_WIDTH).
REQ-011 The block SHALL have port WBS_ACK, output, 1 bit: transfer acknowledge.
REQ-012 The block SHALL have port PWM_OUT, output, NUM_CH bits: channel outputs.
REQ-013 The block SHALL have port PERIOD_IRQ, output, 1 bit: one-cycle pulse at each period wrap when IRQ_EN=1.

Function
REQ-014 The register map SHALL be: 0x00 CTRL (bit0 EN, bit1 UPDATE self-clearing, bit2 IRQ_EN); 0x01 PERIOD; 0x02 STATUS (bit0 UPD_PENDING, RO); 0x10+4*ch+0 DUTY; +1 PHASE; +2 CFG (bit0 CH_EN, bit1 INVERT).
REQ-015 Unmapped indices and indices of channels >= NUM_CH SHALL read 0 and ignore writes, but still be acknowledged.
REQ-016 WBS_ACK SHALL assert exactly one cycle, in the cycle after CYC&STB is first sampled high, and then deassert for at least one cycle (no back-to-back ACK).
REQ-017 Write data SHALL be applied per byte lane enabled by WBS_BYTE_STB; read data SHALL be valid in the ACK cycle, with unused upper bits returning 0.
REQ-018 PERIOD, DUTY and PHASE SHALL be double-buffered: bus writes go to shadow registers, and active copies load only at a period wrap while UPD_PENDING=1.
REQ-019 Writing UPDATE=1 SHALL set UPD_PENDING; UPD_PENDING SHALL clear on the load cycle.
REQ-020 If EN=0 when UPDATE is written, the load SHALL happen on the next cycle.
REQ-021 CTRL and CFG writes SHALL take effect immediately.
REQ-022 The counter SHALL run 0..PERIOD_act-1 while EN=1, then wrap to 0 (a "wrap" event).
REQ-023 When EN=0 the counter SHALL be held at 0.
REQ-024 PERIOD_act=0 SHALL hold the counter at 0 and force all channels inactive.
REQ-025 Channel ch SHALL be active when ((cnt - PHASE_act) mod PERIOD_act) < DUTY_act.
REQ-026 DUTY_act >= PERIOD_act SHALL give a constantly active channel; DUTY_act=0 SHALL give a constantly inactive channel.
REQ-027 PHASE_act >= PERIOD_act SHALL be treated as 0.
REQ-028 The modular subtraction SHALL be done without a divider: a per-channel counter is loaded with PHASE-complement at wrap and wraps at PERIOD.
REQ-029 PWM_OUT[ch] SHALL be registered and equal (active & CH_EN & EN) XOR INVERT, one cycle after the counter value that produced it.
REQ-030 PERIOD_IRQ SHALL pulse in the cycle after a wrap when IRQ_EN=1.
REQ-031 If a bus write to a shadow register coincides with a load cycle, the load SHALL take the old shadow value and the write SHALL land in the shadow.

Reset
REQ-032 Asserting WB_RST SHALL immediately clear all registers, shadows, active copies, counters and UPD_PENDING.
REQ-033 During and after reset, WBS_ACK=0, WBS_RD_DAT=0, PWM_OUT=0 and PERIOD_IRQ=0.
REQ-034 A reset mid-transfer SHALL drop the ACK, and the master re-issues the transfer.

Structure
REQ-035 Register offsets and CTRL/CFG bit positions SHALL live in shared package wishbone_pwm_bank_pkg.
REQ-036 Per-channel phase counter and compare logic SHALL be sub-module pwm_bank_channel, instantiated NUM_CH times via generate.

Verification
REQ-037 PERIOD=10, ch0 DUTY=3 PHASE=0, UPDATE, EN -> PWM_OUT[0] high 3 of every 10 cycles, and PERIOD_IRQ every 10 cycles once IRQ_EN=1.
REQ-038 ch1 DUTY=3 PHASE=5, PERIOD=10 -> ch1 rising edge 5 cycles after the ch0 rising edge; with PHASE=12, ch1 aligns with ch0.
REQ-039 Mid-period, write DUTY=7 without UPDATE -> output unchanged; then write UPDATE -> new duty from the next wrap, and STATUS bit0 reads 1 until the wrap, then 0.
REQ-040 DUTY=0, DUTY=10 and DUTY=15 at PERIOD=10 -> constant 0, 1 and 1; INVERT=1 -> complement; PERIOD=0 -> outputs equal INVERT.
REQ-041 Byte-lane write WBS_BYTE_STB=4'b0001, data 0xFFFF to PERIOD=0x1234 -> shadow reads 0x12FF; read of index 0x7F -> 0 with ACK.
REQ-042 Assert WB_RST mid-period with an ACK pending -> ACK, PWM_OUT and STATUS go to 0 asynchronously, and all registers read 0 after release.
